// File: rtl/ysyx_22040125_dmem_pkg.sv
// Shared types for the RV64 data-memory controller: access sizes, FSM states and strobe helper.
package ysyx_22040125_dmem_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Byte-lane strobe for an access of the given size starting at byte offset off.
    function automatic logic [7:0] strb_mask(input size_e size, input logic [2:0] off);
        logic [7:0] base;
        case (size)
            SZ_B:    base = 8'h01;
            SZ_H:    base = 8'h03;
            SZ_W:    base = 8'h0f;
            default: base = 8'hff;
        endcase
        return base << off;
    endfunction

endpackage

// File: rtl/ysyx_22040125_lsu_align.sv
// Lane alignment for the data-memory controller: store shift/strobe and load extract/extend.
module ysyx_22040125_lsu_align
    import ysyx_22040125_dmem_pkg::*;
#(
    parameter int unsigned DATA_W = 64
) (
    input  size_e             st_size_i,
    input  logic [2:0]        st_off_i,
    input  logic [DATA_W-1:0] st_wdata_i,
    output logic [DATA_W-1:0] st_wdata_o,
    output logic [7:0]        st_strb_o,
    input  size_e             ld_size_i,
    input  logic [2:0]        ld_off_i,
    input  logic              ld_unsigned_i,
    input  logic [DATA_W-1:0] ld_word_i,
    output logic [DATA_W-1:0] ld_data_o
);

    logic [DATA_W-1:0] lane;

    always_comb begin
        st_wdata_o = st_wdata_i << {st_off_i, 3'b000};
        st_strb_o  = strb_mask(st_size_i, st_off_i);
    end

    always_comb begin
        lane = ld_word_i >> {ld_off_i, 3'b000};
        case (ld_size_i)
            SZ_B: ld_data_o = {{(DATA_W-8){~ld_unsigned_i & lane[7]}}, lane[7:0]};
            SZ_H: ld_data_o = {{(DATA_W-16){~ld_unsigned_i & lane[15]}}, lane[15:0]};
            SZ_W: ld_data_o = {{(DATA_W-32){~ld_unsigned_i & lane[31]}}, lane[31:0]};
            default: ld_data_o = lane;
        endcase
    end

endmodule

// File: rtl/ysyx_22040125_dmem_ctrl.sv
// RV64 data-memory controller with valid/ready handshake and configurable read latency.
// Optional DMEM_PERF_EN adds load/store/error counters.
module ysyx_22040125_dmem_ctrl
    import ysyx_22040125_dmem_pkg::*;
#(
    parameter int unsigned       DATA_W     = 64,
    parameter int unsigned       ADDR_W     = 32,
    parameter int unsigned       DEPTH      = 65536,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h8000_0000,
    parameter int unsigned       RD_LATENCY = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
`ifdef DMEM_PERF_EN
    output logic [31:0]       perf_loads_o,
    output logic [31:0]       perf_stores_o,
    output logic [31:0]       perf_errs_o,
`endif
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_unsigned_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              rsp_err_o
);

    localparam int unsigned       IDX_W     = $clog2(DEPTH);
    localparam logic [1:0]        CNT_LAST  = 2'((RD_LATENCY > 1) ? RD_LATENCY - 2 : 0);
    localparam logic [ADDR_W-4:0] DEPTH_LIM = (ADDR_W-3)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] word_q;

    state_e     state_q;
    logic [1:0] cnt_q;
    logic       rsp_valid_q;
    logic [2:0] off_q;
    size_e      size_q;
    logic       unsigned_q, we_q, err_q;

    size_e             req_size;
    logic [ADDR_W-4:0] rel_idx;
    logic [IDX_W-1:0]  idx;
    logic              misaligned, out_of_range, req_err, accept;
    logic [DATA_W-1:0] st_wdata, ld_data;
    logic [7:0]        st_strb;

    assign req_size     = size_e'(req_size_i);
    assign rel_idx      = req_addr_i[ADDR_W-1:3] - BASE_ADDR[ADDR_W-1:3];
    assign idx          = rel_idx[IDX_W-1:0];
    assign misaligned   = (req_addr_i[2:0] & ((3'b001 << req_size_i) - 3'b001)) != 3'b000;
    assign out_of_range = (req_addr_i < BASE_ADDR) || (rel_idx >= DEPTH_LIM);
    assign req_err      = misaligned || out_of_range;
    assign req_ready_o  = (state_q == IDLE) && !rst_i;
    assign accept       = req_valid_i && req_ready_o;

    ysyx_22040125_lsu_align #(
        .DATA_W(DATA_W)
    ) u_align (
        .st_size_i    (req_size),
        .st_off_i     (req_addr_i[2:0]),
        .st_wdata_i   (req_wdata_i),
        .st_wdata_o   (st_wdata),
        .st_strb_o    (st_strb),
        .ld_size_i    (size_q),
        .ld_off_i     (off_q),
        .ld_unsigned_i(unsigned_q),
        .ld_word_i    (word_q),
        .ld_data_o    (ld_data)
    );

    // Array is not reset; the write commits at the accept edge even if a reset follows.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            word_q <= mem_q[idx];
            if (req_we_i && !req_err) begin
                for (int i = 0; i < 8; i++) begin
                    if (st_strb[i]) mem_q[idx][8*i +: 8] <= st_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            off_q       <= '0;
            size_q      <= SZ_B;
            unsigned_q  <= 1'b0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        off_q      <= req_addr_i[2:0];
                        size_q     <= req_size;
                        unsigned_q <= req_unsigned_i;
                        we_q       <= req_we_i;
                        err_q      <= req_err;
                        cnt_q      <= '0;
                        if (RD_LATENCY == 1) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                        end else begin
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == CNT_LAST) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 2'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_err_o   = rsp_valid_q && err_q;
    assign rsp_rdata_o = (rsp_valid_q && !err_q && !we_q) ? ld_data : '0;

`ifdef DMEM_PERF_EN
    logic [31:0] perf_loads_q, perf_stores_q, perf_errs_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_loads_q  <= '0;
            perf_stores_q <= '0;
            perf_errs_q   <= '0;
        end else if (accept) begin
            if (req_err)       perf_errs_q   <= perf_errs_q + 32'd1;
            else if (req_we_i) perf_stores_q <= perf_stores_q + 32'd1;
            else               perf_loads_q  <= perf_loads_q + 32'd1;
        end
    end

    assign perf_loads_o  = perf_loads_q;
    assign perf_stores_o = perf_stores_q;
    assign perf_errs_o   = perf_errs_q;
`endif

endmodule

// File: tb/tb_ysyx_22040125_dmem_ctrl.sv
// Directed bench for ysyx_22040125_dmem_ctrl: a latency-1 instance driven from a vector table
// and a latency-3 instance for timing, backpressure and reset-in-WAIT sequences.
module tb_ysyx_22040125_dmem_ctrl;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [63:0] wdata;
        logic [63:0] exp_rd;
        logic        exp_err;
    } vec_t;

    localparam int NVEC = 25;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst, a_req_valid, a_req_ready, a_we, a_uns, a_rsp_valid, a_rsp_ready, a_rsp_err;
    logic [31:0] a_addr;
    logic [1:0]  a_size;
    logic [63:0] a_wdata, a_rsp_rdata;
    logic        b_rst, b_req_valid, b_req_ready, b_we, b_uns, b_rsp_valid, b_rsp_ready, b_rsp_err;
    logic [31:0] b_addr;
    logic [1:0]  b_size;
    logic [63:0] b_wdata, b_rsp_rdata;

    int errs = 0;
    int checks = 0;

    ysyx_22040125_dmem_ctrl u_dut_a (
        .clk_i         (clk),
        .rst_i         (a_rst),
        .req_valid_i   (a_req_valid),
        .req_ready_o   (a_req_ready),
        .req_we_i      (a_we),
        .req_addr_i    (a_addr),
        .req_size_i    (a_size),
        .req_unsigned_i(a_uns),
        .req_wdata_i   (a_wdata),
        .rsp_valid_o   (a_rsp_valid),
        .rsp_ready_i   (a_rsp_ready),
        .rsp_rdata_o   (a_rsp_rdata),
        .rsp_err_o     (a_rsp_err)
    );

    ysyx_22040125_dmem_ctrl #(
        .DEPTH     (1024),
        .RD_LATENCY(3)
    ) u_dut_b (
        .clk_i         (clk),
        .rst_i         (b_rst),
        .req_valid_i   (b_req_valid),
        .req_ready_o   (b_req_ready),
        .req_we_i      (b_we),
        .req_addr_i    (b_addr),
        .req_size_i    (b_size),
        .req_unsigned_i(b_uns),
        .req_wdata_i   (b_wdata),
        .rsp_valid_o   (b_rsp_valid),
        .rsp_ready_i   (b_rsp_ready),
        .rsp_rdata_o   (b_rsp_rdata),
        .rsp_err_o     (b_rsp_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One full transaction on instance a (b=0) or b (b=1) with rsp_ready held high.
    task automatic xact(input bit b, input vec_t v, output logic [63:0] rd, output logic er,
                        output int lat);
        int n = 0;
        @(negedge clk);
        if (b) begin
            b_req_valid = 1'b1; b_we = v.we; b_addr = v.addr; b_size = v.size;
            b_uns = v.uns; b_wdata = v.wdata; b_rsp_ready = 1'b1;
        end else begin
            a_req_valid = 1'b1; a_we = v.we; a_addr = v.addr; a_size = v.size;
            a_uns = v.uns; a_wdata = v.wdata; a_rsp_ready = 1'b1;
        end
        while (!(b ? b_req_ready : a_req_ready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        @(negedge clk);
        a_req_valid = 1'b0;
        b_req_valid = 1'b0;
        lat = 1;
        while (!(b ? b_rsp_valid : a_rsp_valid) && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rd = b ? b_rsp_rdata : a_rsp_rdata;
        er = b ? b_rsp_err : a_rsp_err;
        @(posedge clk);
    endtask

    vec_t        vecs [NVEC];
    vec_t        v;
    logic [63:0] rd;
    logic        er;
    int          lat;
    logic        seen;

    initial begin
        // we, addr, size, uns, wdata, exp_rdata, exp_err
        vecs[0]  = '{1'b1, 32'h8000_0010, 2'd3, 1'b0, 64'h1122334455667788, 64'h0, 1'b0};
        vecs[1]  = '{1'b0, 32'h8000_0010, 2'd3, 1'b0, 64'h0, 64'h1122334455667788, 1'b0};
        vecs[2]  = '{1'b1, 32'h8000_0013, 2'd0, 1'b0, 64'h123456789ABCDEFF, 64'h0, 1'b0};
        vecs[3]  = '{1'b0, 32'h8000_0013, 2'd0, 1'b0, 64'h0, 64'hFFFFFFFFFFFFFFFF, 1'b0};
        vecs[4]  = '{1'b0, 32'h8000_0013, 2'd0, 1'b1, 64'h0, 64'h00000000000000FF, 1'b0};
        vecs[5]  = '{1'b0, 32'h8000_0010, 2'd3, 1'b0, 64'h0, 64'h11223344FF667788, 1'b0};
        vecs[6]  = '{1'b0, 32'h8000_0011, 2'd1, 1'b0, 64'h0, 64'h0, 1'b1};
        vecs[7]  = '{1'b1, 32'h8000_0000, 2'd3, 1'b0, 64'h0123456789ABCDEF, 64'h0, 1'b0};
        vecs[8]  = '{1'b1, 32'h8000_0002, 2'd2, 1'b0, 64'h00000000DEADBEEF, 64'h0, 1'b1};
        vecs[9]  = '{1'b0, 32'h8000_0000, 2'd3, 1'b0, 64'h0, 64'h0123456789ABCDEF, 1'b0};
        vecs[10] = '{1'b0, 32'h7FFF_FFF8, 2'd3, 1'b0, 64'h0, 64'h0, 1'b1};
        vecs[11] = '{1'b0, 32'h8008_0000, 2'd3, 1'b0, 64'h0, 64'h0, 1'b1};
        vecs[12] = '{1'b1, 32'h8007_FFF8, 2'd3, 1'b0, 64'hCAFEF00DDEADBEEF, 64'h0, 1'b0};
        vecs[13] = '{1'b0, 32'h8007_FFF8, 2'd3, 1'b0, 64'h0, 64'hCAFEF00DDEADBEEF, 1'b0};
        vecs[14] = '{1'b1, 32'h8000_0018, 2'd3, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'h0, 1'b0};
        vecs[15] = '{1'b1, 32'h8000_0018, 2'd2, 1'b0, 64'h0123456789ABCDEF, 64'h0, 1'b0};
        vecs[16] = '{1'b1, 32'h8000_001A, 2'd1, 1'b0, 64'h0000000000008001, 64'h0, 1'b0};
        vecs[17] = '{1'b0, 32'h8000_0018, 2'd3, 1'b0, 64'h0, 64'hFFFFFFFF8001CDEF, 1'b0};
        vecs[18] = '{1'b0, 32'h8000_001A, 2'd1, 1'b0, 64'h0, 64'hFFFFFFFFFFFF8001, 1'b0};
        vecs[19] = '{1'b0, 32'h8000_001A, 2'd1, 1'b1, 64'h0, 64'h0000000000008001, 1'b0};
        vecs[20] = '{1'b0, 32'h8000_0018, 2'd2, 1'b0, 64'h0, 64'hFFFFFFFF8001CDEF, 1'b0};
        vecs[21] = '{1'b0, 32'h8000_0018, 2'd2, 1'b1, 64'h0, 64'h000000008001CDEF, 1'b0};
        vecs[22] = '{1'b0, 32'h8000_0018, 2'd3, 1'b1, 64'h0, 64'hFFFFFFFF8001CDEF, 1'b0};
        vecs[23] = '{1'b0, 32'h8000_0004, 2'd3, 1'b0, 64'h0, 64'h0, 1'b1};
        vecs[24] = '{1'b0, 32'h8000_0016, 2'd1, 1'b0, 64'h0, 64'h0000000000001122, 1'b0};

        a_rst = 1'b1; a_req_valid = 1'b0; a_we = 1'b0; a_addr = '0; a_size = '0; a_uns = 1'b0;
        a_wdata = '0; a_rsp_ready = 1'b1;
        b_rst = 1'b1; b_req_valid = 1'b0; b_we = 1'b0; b_addr = '0; b_size = '0; b_uns = 1'b0;
        b_wdata = '0; b_rsp_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst req_ready", a_req_ready, 0);
        chk("rst rsp_valid", a_rsp_valid, 0);
        chk("rst rsp_rdata", a_rsp_rdata, 0);
        chk("rst rsp_err", a_rsp_err, 0);
        a_rst = 1'b0;
        b_rst = 1'b0;
        @(negedge clk);
        chk("post-rst a req_ready", a_req_ready, 1);
        chk("post-rst b req_ready", b_req_ready, 1);

        for (int i = 0; i < NVEC; i++) begin
            xact(1'b0, vecs[i], rd, er, lat);
            chk($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rd);
            chk($sformatf("vec%0d err", i), er, vecs[i].exp_err);
            chk($sformatf("vec%0d latency", i), lat, 1);
        end

        // Latency-3 instance: store, then timed load with backpressure.
        v = '{1'b1, 32'h8000_0040, 2'd3, 1'b0, 64'h55AA55AA12345678, 64'h0, 1'b0};
        xact(1'b1, v, rd, er, lat);
        chk("b store err", er, 0);
        chk("b store latency", lat, 3);

        @(negedge clk);
        b_req_valid = 1'b1; b_we = 1'b0; b_addr = 32'h8000_0040; b_size = 2'd3; b_uns = 1'b0;
        b_rsp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        b_req_valid = 1'b0;
        chk("b N+1 rsp_valid", b_rsp_valid, 0);
        @(negedge clk);
        chk("b N+2 rsp_valid", b_rsp_valid, 0);
        @(negedge clk);
        chk("b N+3 rsp_valid", b_rsp_valid, 1);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("b hold%0d rsp_valid", i), b_rsp_valid, 1);
            chk($sformatf("b hold%0d rdata", i), b_rsp_rdata, 64'h55AA55AA12345678);
            chk($sformatf("b hold%0d err", i), b_rsp_err, 0);
            chk($sformatf("b hold%0d req_ready", i), b_req_ready, 0);
            @(negedge clk);
        end
        b_rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("b after hs rsp_valid", b_rsp_valid, 0);
        chk("b after hs req_ready", b_req_ready, 1);

        // Reset while in WAIT after a store accept: response dropped, store kept.
        b_req_valid = 1'b1; b_we = 1'b1; b_addr = 32'h8000_0080; b_size = 2'd3;
        b_wdata = 64'h0F0E0D0C0B0A0908;
        @(posedge clk);
        @(negedge clk);
        b_req_valid = 1'b0;
        b_rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b_rst = 1'b0;
        seen = b_rsp_valid;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (b_rsp_valid) seen = 1'b1;
        end
        chk("b rst-in-wait rsp_valid seen", seen, 0);
        chk("b rst-in-wait req_ready", b_req_ready, 1);
        v = '{1'b0, 32'h8000_0080, 2'd3, 1'b0, 64'h0, 64'h0, 1'b0};
        xact(1'b1, v, rd, er, lat);
        chk("b reload rdata", rd, 64'h0F0E0D0C0B0A0908);
        chk("b reload err", er, 0);
        chk("b reload latency", lat, 3);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
